led_pattern: RTL

- Parametrised LED pattern generator that drives a board LED bank.
- A programmable period divider produces step events; each step advances the LED vector according to a runtime-selected mode.
- Modes: rotate-left, rotate-right, bounce (ping-pong) and blink.
- Sits at the top level next to the board pin constraints; all inputs come from switches or a CSR and are synchronous to clk.

---
 rtl/led_pattern_pkg.sv | 24 ++
 rtl/led_pattern_if.sv | 15 +
 rtl/led_pattern_step_divider.sv | 32 +++
 rtl/led_pattern.sv | 89 ++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// Shared constants for the LED pattern generator: mode codes, bounce
// direction and the per-mode seed pattern.
package led_pattern_pkg;

    localparam logic [1:0] MODE_ROTL   = 2'd0;
    localparam logic [1:0] MODE_ROTR   = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Widest LED bank the seed helper covers; callers cast down to their WIDTH.
    localparam int SEED_W = 64;

    function automatic logic [SEED_W-1:0] seed(input logic [1:0] mode);
        if (mode == MODE_BLINK)
            return '1;
        return SEED_W'(1);
    endfunction

endpackage

// File: rtl/led_pattern_if.sv
// Control and LED bundle of the pattern generator; the controller side is
// the master, the generator the slave.
interface led_pattern_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32
) ();
    logic             en;
    logic [1:0]       mode;
    logic [CNT_W-1:0] period;
    logic [WIDTH-1:0] led;
    logic             tick;

    modport master (output en, output mode, output period, input led, input tick);
    modport slave  (input en, input mode, input period, output led, output tick);
endinterface

// File: rtl/led_pattern_step_divider.sv
// Period divider: counts enabled cycles and flags a step once the count
// reaches the programmed period; clr restarts the interval.
module step_divider #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] period,
    output logic             step
);

    logic [CNT_W-1:0] count;

    // >= rather than == so a period lowered below the count steps at once.
    assign step = en && !clr && (count >= period);

    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (!en)
            count <= count;
        else if (step)
            count <= '0;
        else
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/led_pattern.sv
// LED pattern generator: rotate-left, rotate-right, bounce and blink,
// advancing once per divider step. WIDTH must lie in 2..SEED_W.
module led_pattern
    import led_pattern_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    led_pattern_if.slave bus
);

    logic [1:0]       mode_q, mode_d;
    dir_t             dir_q, dir_d;
    logic [WIDTH-1:0] led_q, led_d, led_seed;
    logic             tick_q, tick_d;
    logic             mode_chg;
    logic             step;

    assign mode_chg = (bus.mode != mode_q);
    assign led_seed = WIDTH'(seed(bus.mode));

    step_divider #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (bus.en),
        .clr    (mode_chg),
        .period (bus.period),
        .step   (step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= MODE_ROTL;
            dir_q  <= DIR_UP;
            led_q  <= WIDTH'(1);
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            dir_q  <= dir_d;
            led_q  <= led_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        dir_d  = dir_q;
        led_d  = led_q;
        tick_d = 1'b0;
        if (mode_chg) begin
            mode_d = bus.mode;
            led_d  = led_seed;
            dir_d  = DIR_UP;
        end else if (step) begin
            tick_d = 1'b1;
            case (mode_q)
                MODE_ROTL: led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
                MODE_ROTR: led_d = {led_q[0], led_q[WIDTH-1:1]};
                MODE_BOUNCE: begin
                    // Turn around on reaching an end so each end lights for one step only.
                    if (dir_q == DIR_UP) begin
                        if (led_q[WIDTH-1]) begin
                            led_d = led_q >> 1;
                            dir_d = DIR_DOWN;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            led_d = led_q << 1;
                            dir_d = DIR_UP;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                end
                default: led_d = ~led_q;
            endcase
        end
    end

    assign bus.led  = led_q;
    assign bus.tick = tick_q;

endmodule
